// File: rtl/stall_ctrl.sv
// Pipeline stall generator and shared memory port arbiter between IF and MEM.
// MEM accesses win the port; busy requesters are turned into stall requests.
module stall_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_mem_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              id_stallreq,
  input  logic              ex_stallreq,
  output logic [5:0]        stall,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT} state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;
  logic                if_busy, mem_busy;

  // The done pulse masks a still-held request so it is not re-issued.
  assign if_busy  = if_mem_req  & ~if_done_q;
  assign mem_busy = mem_mem_req & ~mem_done_q;

  always_comb begin
    stall = 6'b000000;
    if (mem_busy)         stall = 6'b011111;
    else if (ex_stallreq) stall = 6'b001111;
    else if (id_stallreq) stall = 6'b000111;
    else if (if_busy)     stall = 6'b000011;
  end

  always_comb begin
    state_d        = state_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    if_done_d      = 1'b0;
    mem_done_d     = 1'b0;
    if_rdata_d     = if_rdata_q;
    mem_rdata_d    = mem_rdata_q;
    stall_cycles_d = stall[0] ? stall_cycles_q + 32'd1 : stall_cycles_q;
    case (state_q)
      IDLE: begin
        if (mem_busy) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          state_d     = MEM_WAIT;
        end else if (if_busy) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr;
          state_d    = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (bus_ack) begin
          bus_req_d  = 1'b0;
          if_rdata_d = bus_rdata;
          if_done_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      MEM_WAIT: begin
        if (bus_ack) begin
          bus_req_d   = 1'b0;
          mem_rdata_d = bus_rdata;
          mem_done_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      if_done_q      <= 1'b0;
      mem_done_q     <= 1'b0;
      if_rdata_q     <= '0;
      mem_rdata_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      if_done_q      <= if_done_d;
      mem_done_q     <= mem_done_d;
      if_rdata_q     <= if_rdata_d;
      mem_rdata_q    <= mem_rdata_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign if_done      = if_done_q;
  assign mem_done     = mem_done_q;
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign stall_cycles = stall_cycles_q;

endmodule
